// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice:
// FSM state encoding, data/lane widths and the wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port data RAM with per-byte write enables and a
// registered read port that only updates on a read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [LANES-1:0]      wr_en,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Contents survive reset; only the enabled byte lanes are touched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem[index][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[index];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: accept, wait WAIT_CYCLES, access, pulse valid.
// Optional macro DMEM_RANGE_CHECK_EN adds an err port and blocks out-of-range accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              re_we,
  input  logic [LANES-1:0]  mask,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic              busy
`ifdef DMEM_RANGE_CHECK_EN
  ,output logic             err
`endif
);

  dmem_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] hold_idx;
  logic                  hold_we;
  logic [LANES-1:0]      hold_mask;
  logic [DATA_W-1:0]     hold_data;
  logic                  hold_oor;
  logic                  zero_q;
  logic                  in_oor;
  logic                  acc_oor;
  logic                  in_idle;
  logic                  fire;
  logic                  block;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_we;
  logic [LANES-1:0]      acc_mask;
  logic [DATA_W-1:0]     acc_data;
  logic [DATA_W-1:0]     ram_rd;
  logic                  unused_bits;

  if (DEPTH_LOG2 < 30) begin : g_oor
    assign in_oor = |address[DATA_W-1:DEPTH_LOG2+2];
  end else begin : g_no_oor
    assign in_oor = 1'b0;
  end

  // With zero wait states the access fires straight out of IDLE, so the
  // array sees the live inputs instead of the holding registers.
  assign in_idle  = (state == IDLE);
  assign fire     = (in_idle && request && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == '0));
  assign acc_idx  = in_idle ? address[DEPTH_LOG2+1:2] : hold_idx;
  assign acc_we   = in_idle ? re_we      : hold_we;
  assign acc_mask = in_idle ? mask       : hold_mask;
  assign acc_data = in_idle ? store_data : hold_data;

`ifdef DMEM_RANGE_CHECK_EN
  assign acc_oor = in_idle ? in_oor : hold_oor;
`else
  assign acc_oor = 1'b0;
`endif

  assign block       = rst || acc_oor;
  assign load_data   = zero_q ? '0 : ram_rd;
  assign unused_bits = &{1'b0, address[1:0], hold_oor, in_oor};

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (fire && !acc_we && !block),
    .wr_en   ((fire && acc_we && !block) ? acc_mask : '0),
    .index   (acc_idx),
    .wr_data (acc_data),
    .rd_data (ram_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      zero_q <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (request) begin
            hold_idx  <= address[DEPTH_LOG2+1:2];
            hold_we   <= re_we;
            hold_mask <= mask;
            hold_data <= store_data;
            hold_oor  <= in_oor;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              valid <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
              err   <= in_oor;
`endif
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            valid <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
            err   <= hold_oor;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // An out-of-range load must read back as zero until the next load.
      if (fire && !acc_we) zero_q <= acc_oor;
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the load/store data-memory interface driven by the memory stage: request, re_we, mask, address, store data in; load word and completion strobe out.
Holds a word-addressed, byte-lane-writable data array and completes each access after a configurable number of wait states.
Returns the full aligned 32-bit word; lane extraction and sign extension stay in the memory-stage wrapper.

Parameters:
DEPTH_LOG2, 10, log2 of array depth in 32-bit words (default 1024 words = 4 KiB)
WAIT_CYCLES, 1, wait states inserted between accept and completion; legal range 0..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
request  input  1  access request level; held by initiator until valid
re_we  input  1  1 = store, 0 = load; sampled with request
mask  input  4  byte-lane write enables, bit i = byte lane i; ignored for loads
address  input  32  byte address; bits [DEPTH_LOG2+1:2] select the word, bits [1:0] ignored
store_data  input  32  lane-positioned store data
load_data  output  32  registered read word; holds until the next load completes
valid  output  1  one-cycle completion pulse for load or store
busy  output  1  high while an access is in flight (state != IDLE)

Behaviour:
- Reset (rst=1 at an edge): state IDLE, valid=0, busy=0, load_data=0, wait counter=0. Array contents are not cleared. Reset mid-access discards the pending access; a pending store is not written.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if request=1, capture address word index, re_we, mask, store_data into holding registers. Go to WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise go straight to RESP. If request=0, stay in IDLE.
- WAIT: if cnt==0 go to RESP, else decrement cnt. Input changes are ignored.
- Access is performed on the edge that enters RESP, from the captured values.
  - Store: each byte lane with mask[i]=1 is written; other lanes are unchanged. load_data is unchanged.
  - Load: load_data <= array[index].
- RESP: valid=1 for exactly this cycle; always go to IDLE next. This gives one idle bubble between accesses.
- Latency: with request first high in cycle 0, valid is high in cycle WAIT_CYCLES+1. The first possible re-accept is in cycle WAIT_CYCLES+2.
- Store with mask=4'b0000 completes normally with valid and no array change.
- Out-of-range address (any bit of address[31:DEPTH_LOG2+2] set) is handled by the optional feature below.
- No read-during-write hazard: only one access is in flight at a time.
- Port widths are fixed at 32-bit data and 4-bit mask; the index is truncated to DEPTH_LOG2 bits.

Optional Feature:
Macro DMEM_RANGE_CHECK_EN.
- Defined: adds output port err (1 bit, reset 0).
  - On an out-of-range access, err pulses together with valid.
  - A store is suppressed entirely.
  - A load sets load_data=32'h0000_0000.
- Undefined: no err port; out-of-range addresses wrap modulo the array depth.

Decomposition:
- Package dmem_pkg:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - data width 32 and lane count 4
  - WAIT counter width 4
- One sub-module: dmem_array, a synchronous single-port RAM with per-byte write enables and a registered read.
- data_mem_responder contains the FSM, holding registers, counter and optional range check.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, request=0 → load_data=0, valid=0, busy=0 throughout.
2. Full-word store then load (WAIT_CYCLES=1):
   - Store addr 0x10, mask 4'b1111, data 0xDEADBEEF → valid in cycle 2.
   - Then load addr 0x10 → load_data=0xDEADBEEF with valid in cycle 2 of the load.
3. Byte-lane store: word 0x20 preloaded with 0x11223344, store mask 4'b0100, data 0x00AA0000 → load returns 0x11AA3344.
4. Latency sweep, WAIT_CYCLES=0 and 15, request held high → valid exactly 1 and 16 cycles after the first request cycle; busy high from accept through RESP; request ignored while busy.
5. Reset mid-access: store issued, rst asserted in the WAIT cycle → no valid pulse, word unchanged on read-back, FSM in IDLE.
6. DEPTH_LOG2=10, load from address 0x0000_1004:
   - With DMEM_RANGE_CHECK_EN → err=1 with valid, load_data=0.
   - Without it → returns the word at index 1.
